// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port BRAM between the instruction-fetch port (read-only)
// and the data port (read/write). Arbitration is combinational and round-robin
// on ties, so a grant can be issued every cycle. Each grant pushes a response
// tag into an RD_LAT-deep pipeline. When the tag leaves the pipeline it routes
// BRAM_DOUT back to the port that issued the read. Out-of-range addresses are
// still granted but never write the BRAM; they come back flagged with ERR.
module bram_port_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BRAM_DEPTH  = 1024,
    parameter int BRAM_ADDR_W = $clog2(BRAM_DEPTH),
    parameter int RD_LAT      = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,

    input  logic                   IF_REQ,
    input  logic [ADDR_W-1:0]      IF_ADDR,
    output logic                   IF_GNT,
    output logic                   IF_RVALID,
    output logic [DATA_W-1:0]      IF_RDATA,
    output logic                   IF_ERR,

    input  logic                   D_REQ,
    input  logic [DATA_W/8-1:0]    D_WE,
    input  logic [ADDR_W-1:0]      D_ADDR,
    input  logic [DATA_W-1:0]      D_WDATA,
    output logic                   D_GNT,
    output logic                   D_RVALID,
    output logic [DATA_W-1:0]      D_RDATA,
    output logic                   D_ERR,

    output logic [DATA_W/8-1:0]    BRAM_WE,
    output logic [BRAM_ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_W-1:0]      BRAM_DIN,
    input  logic [DATA_W-1:0]      BRAM_DOUT
);

    localparam int WORD_W = ADDR_W - 2;
    localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(BRAM_DEPTH);

    // Port identifiers, used both for last_gnt and for the tag port field.
    localparam logic [0:0] PORT_IF = 1'b0;
    localparam logic [0:0] PORT_D  = 1'b1;

    logic [0:0]             last_gnt;
    logic                   gnt_if;
    logic                   gnt_d;
    logic                   any_gnt;
    logic                   if_oor;
    logic                   d_oor;
    logic [BRAM_ADDR_W-1:0] if_waddr;
    logic [BRAM_ADDR_W-1:0] d_waddr;
    logic [BRAM_ADDR_W-1:0] addr_hold;
    logic [BRAM_ADDR_W-1:0] bram_addr_c;
    logic [DATA_W/8-1:0]    bram_we_c;

    logic [0:0]             new_port;
    logic                   new_read;
    logic                   new_err;

    logic [RD_LAT-1:0]      tag_valid;
    logic [RD_LAT-1:0]      tag_port;
    logic [RD_LAT-1:0]      tag_read;
    logic [RD_LAT-1:0]      tag_err;

    logic                   rsp_valid;
    logic [0:0]             rsp_port;
    logic                   rsp_read;
    logic                   rsp_err;

    // The byte offset within a word never affects the access.
    logic                   unused_addr_lsbs;
    assign unused_addr_lsbs = ^{IF_ADDR[1:0], D_ADDR[1:0]};

    assign if_oor   = IF_ADDR[ADDR_W-1:2] >= DEPTH_WORDS;
    assign d_oor    = D_ADDR[ADDR_W-1:2] >= DEPTH_WORDS;
    assign if_waddr = IF_ADDR[BRAM_ADDR_W+1:2];
    assign d_waddr  = D_ADDR[BRAM_ADDR_W+1:2];

    // D wins a tie unless it was the last port served, and IF takes every
    // cycle that D does not win. Reset masks both grants.
    assign gnt_d   = !ARESET && D_REQ && (!IF_REQ || (last_gnt == PORT_IF));
    assign gnt_if  = !ARESET && IF_REQ && !gnt_d;
    assign any_gnt = gnt_d || gnt_if;

    assign IF_GNT  = gnt_if;
    assign D_GNT   = gnt_d;

    // Drive the BRAM port from the winner and build the tag for this grant.
    always_comb begin
        bram_addr_c = addr_hold;
        bram_we_c   = '0;
        new_port    = PORT_IF;
        new_read    = 1'b0;
        new_err     = 1'b0;
        if (gnt_d) begin
            bram_addr_c = d_waddr;
            new_port    = PORT_D;
            new_read    = (D_WE == '0);
            new_err     = d_oor;
            if (!d_oor) begin
                bram_we_c = D_WE;
            end
        end else if (gnt_if) begin
            bram_addr_c = if_waddr;
            new_port    = PORT_IF;
            new_read    = 1'b1;
            new_err     = if_oor;
        end
    end

    assign BRAM_ADDR = bram_addr_c;
    assign BRAM_WE   = bram_we_c;
    assign BRAM_DIN  = D_WDATA;

    // Remember the last winner for round-robin and the last address driven so
    // the BRAM address holds steady across idle cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_gnt  <= PORT_IF;
            addr_hold <= '0;
        end else if (any_gnt) begin
            last_gnt  <= gnt_d ? PORT_D : PORT_IF;
            addr_hold <= bram_addr_c;
        end
    end

    // The response tag pipeline. Its depth equals the BRAM read latency, so the
    // tag at the last stage lines up with BRAM_DOUT for that access.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tag_valid <= '0;
            tag_port  <= '0;
            tag_read  <= '0;
            tag_err   <= '0;
        end else begin
            tag_valid[0] <= any_gnt;
            tag_port[0]  <= new_port[0];
            tag_read[0]  <= new_read;
            tag_err[0]   <= new_err;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
                tag_read[i]  <= tag_read[i-1];
                tag_err[i]   <= tag_err[i-1];
            end
        end
    end

    assign rsp_valid = tag_valid[RD_LAT-1] && !ARESET;
    assign rsp_port  = tag_port[RD_LAT-1];
    assign rsp_read  = tag_read[RD_LAT-1];
    assign rsp_err   = tag_err[RD_LAT-1];

    // Errored reads return zero data instead of whatever the BRAM produced.
    assign IF_RVALID = rsp_valid && (rsp_port == PORT_IF) && rsp_read;
    assign IF_ERR    = rsp_valid && (rsp_port == PORT_IF) && rsp_err;
    assign IF_RDATA  = (IF_RVALID && !rsp_err) ? BRAM_DOUT : '0;

    assign D_RVALID  = rsp_valid && (rsp_port == PORT_D) && rsp_read;
    assign D_ERR     = rsp_valid && (rsp_port == PORT_D) && rsp_err;
    assign D_RDATA   = (D_RVALID && !rsp_err) ? BRAM_DOUT : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter. A behavioural BRAM sits on the main instance
// (RD_LAT=1). A word-array reference model predicts the grants and the responses
// in a scoreboard. A second instance with RD_LAT=2 covers the latency and the
// behaviour when reset arrives mid-flight.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

    localparam int DEPTH = 1024;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    logic        ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        areset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din, bram_dout;

    logic        r2;
    logic        d2_req;
    logic [31:0] d2_addr;
    logic        d2_gnt, d2_rvalid, d2_err;
    logic [31:0] d2_rdata;
    logic [31:0] d2_dout;
    logic        unused2_if_gnt, unused2_if_rvalid, unused2_if_err;
    logic [31:0] unused2_if_rdata, unused2_bram_din;
    logic [3:0]  unused2_bram_we;
    logic [9:0]  unused2_bram_addr;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] bram_mem [0:DEPTH-1];
    rsp_t        if_q[$];
    rsp_t        d_q[$];
    bit          grant_log[$];
    bit          last_d;
    bit          hold_known;
    int          hold_w;
    logic [31:0] last_if_rdata, last_d_rdata;
    bit          last_if_err, last_d_err;

    bram_port_arbiter #(.RD_LAT(1)) dut (
        .ACLK(ACLK), .ARESET(areset),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt),
        .IF_RVALID(if_rvalid), .IF_RDATA(if_rdata), .IF_ERR(if_err),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(d_gnt), .D_RVALID(d_rvalid), .D_RDATA(d_rdata), .D_ERR(d_err),
        .BRAM_WE(bram_we), .BRAM_ADDR(bram_addr), .BRAM_DIN(bram_din),
        .BRAM_DOUT(bram_dout)
    );

    bram_port_arbiter #(.RD_LAT(2)) dut2 (
        .ACLK(ACLK), .ARESET(r2),
        .IF_REQ(1'b0), .IF_ADDR(32'h0), .IF_GNT(unused2_if_gnt),
        .IF_RVALID(unused2_if_rvalid), .IF_RDATA(unused2_if_rdata), .IF_ERR(unused2_if_err),
        .D_REQ(d2_req), .D_WE(4'h0), .D_ADDR(d2_addr), .D_WDATA(32'h0),
        .D_GNT(d2_gnt), .D_RVALID(d2_rvalid), .D_RDATA(d2_rdata), .D_ERR(d2_err),
        .BRAM_WE(unused2_bram_we), .BRAM_ADDR(unused2_bram_addr), .BRAM_DIN(unused2_bram_din),
        .BRAM_DOUT(d2_dout)
    );

    function automatic logic [31:0] init_word(input int i);
        return {16'(i) ^ 16'h5A5A, ~16'(i)};
    endfunction

    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural single-port BRAM with one cycle of read latency.
    always @(posedge ACLK) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) bram_mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
        bram_dout <= bram_mem[bram_addr];
    end

    // Reference model: predict the grant, check the BRAM port and push the expected responses.
    always @(negedge ACLK) begin
        bit exp_if, exp_d, inr, rd;
        logic [31:0] a;
        logic [3:0] ewe;
        int w;
        rsp_t e;
        if (areset) begin
            checks++;
            if (if_gnt || d_gnt || bram_we != 4'h0 || if_rvalid || d_rvalid || if_err || d_err ||
                if_rdata != 32'h0 || d_rdata != 32'h0) begin
                errors++;
                $display("FAIL reset_outputs got gnt=%b/%b we=%h rv=%b/%b err=%b/%b exp all zero",
                         if_gnt, d_gnt, bram_we, if_rvalid, d_rvalid, if_err, d_err);
            end
            last_d = 1'b0;
            hold_known = 1'b0;
            if_q.delete();
            d_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        end else begin
            exp_if = if_req;
            exp_d  = d_req;
            if (if_req && d_req) begin
                exp_d  = !last_d;
                exp_if = last_d;
            end
            checks++;
            if (if_gnt !== exp_if || d_gnt !== exp_d) begin
                errors++;
                $display("FAIL grant cyc=%0d got if/d=%b/%b exp=%b/%b", cyc, if_gnt, d_gnt, exp_if, exp_d);
            end
            if (d_gnt) grant_log.push_back(1'b1);
            else if (if_gnt) grant_log.push_back(1'b0);
            if (exp_d || exp_if) begin
                a   = exp_d ? d_addr : if_addr;
                inr = (a >> 2) < DEPTH;
                w   = int'((a >> 2) % DEPTH);
                rd  = exp_if || (d_we == 4'h0);
                ewe = (exp_d && inr && !rd) ? d_we : 4'h0;
                checks++;
                if (bram_addr !== 10'(w) || bram_we !== ewe || (exp_d && bram_din !== d_wdata)) begin
                    errors++;
                    $display("FAIL bram_port cyc=%0d got addr=%h we=%h din=%h exp addr=%h we=%h din=%h",
                             cyc, bram_addr, bram_we, bram_din, 10'(w), ewe, d_wdata);
                end
                e.cyc = cyc + 1;
                e.rd = rd;
                e.err = !inr;
                e.data = (rd && inr) ? ref_mem[w] : 32'h0;
                if (rd || !inr) begin
                    if (exp_d) d_q.push_back(e);
                    else if_q.push_back(e);
                end
                if (exp_d && !rd && inr)
                    for (int b = 0; b < 4; b++)
                        if (d_we[b]) ref_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
                last_d = exp_d;
                hold_w = w;
                hold_known = 1'b1;
            end else begin
                checks++;
                if (bram_we !== 4'h0 || (hold_known && bram_addr !== 10'(hold_w))) begin
                    errors++;
                    $display("FAIL idle_port cyc=%0d got we=%h addr=%h exp we=0 addr=%h",
                             cyc, bram_we, bram_addr, 10'(hold_w));
                end
            end
        end
    end

    task automatic cmp_rsp(input string nm, input rsp_t e, input bit rv, input bit er, input logic [31:0] rdat);
        checks++;
        if (rv !== e.rd || er !== e.err || rdat !== e.data) begin
            errors++;
            $display("FAIL %s cyc=%0d got rvalid=%b err=%b data=%h exp rvalid=%b err=%b data=%h",
                     nm, cyc, rv, er, rdat, e.rd, e.err, e.data);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge ACLK) begin
        rsp_t e;
        if (!areset) begin
            while (if_q.size() > 0 && if_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL if_missed got none exp response at cyc=%0d", if_q[0].cyc);
                void'(if_q.pop_front());
            end
            while (d_q.size() > 0 && d_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL d_missed got none exp response at cyc=%0d", d_q[0].cyc);
                void'(d_q.pop_front());
            end
            if (if_rvalid || if_err) begin
                if (if_q.size() == 0 || if_q[0].cyc != cyc) begin
                    checks++; errors++;
                    $display("FAIL if_unexpected cyc=%0d got rvalid=%b err=%b exp none", cyc, if_rvalid, if_err);
                end else begin
                    e = if_q.pop_front();
                    cmp_rsp("if_rsp", e, if_rvalid, if_err, if_rdata);
                end
                last_if_rdata = if_rdata;
                last_if_err = if_err;
            end else begin
                checks++;
                if (if_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL if_rdata_idle got=%h exp=0", if_rdata);
                end
            end
            if (d_rvalid || d_err) begin
                if (d_q.size() == 0 || d_q[0].cyc != cyc) begin
                    checks++; errors++;
                    $display("FAIL d_unexpected cyc=%0d got rvalid=%b err=%b exp none", cyc, d_rvalid, d_err);
                end else begin
                    e = d_q.pop_front();
                    cmp_rsp("d_rsp", e, d_rvalid, d_err, d_rdata);
                end
                last_d_rdata = d_rdata;
                last_d_err = d_err;
            end else begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL d_rdata_idle got=%h exp=0", d_rdata);
                end
            end
        end
    end

    task automatic do_if(input logic [31:0] a, input bit keep);
        bit ok = 1'b0;
        if_req = 1'b1;
        if_addr = a;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge ACLK); #1;
            ok = if_gnt;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL if_gnt_timeout got=0 exp=1 addr=%h", a);
        end
        @(posedge ACLK); #1;
        if (!keep || !ok) if_req = 1'b0;
    endtask

    task automatic do_d(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd, input bit keep);
        bit ok = 1'b0;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge ACLK); #1;
            ok = d_gnt;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL d_gnt_timeout got=0 exp=1 addr=%h", a);
        end
        @(posedge ACLK); #1;
        if (!keep || !ok) d_req = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        if (r == 8) return 32'h1000 + 32'($urandom_range(0, 255));
        return $urandom | 32'h8000_0000;
    endfunction

    task automatic check2(input string nm, input bit got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_pat [6];
        exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        d2_dout = 32'h1234_5678;
        r2 = 1'b1;
        d2_req = 1'b0;
        d2_addr = 32'h0;
        areset = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h40;
        d_req = 1'b1;
        d_we = 4'hF;
        d_addr = 32'h44;
        d_wdata = 32'h1111_1111;
        repeat (3) @(posedge ACLK);
        #1;
        areset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        d_we = 4'h0;

        // Contention right after reset: D wins the first tie, then they alternate.
        grant_log.delete();
        fork
            begin
                do_d(4'h0, 32'h100, 32'h0, 1'b1);
                do_d(4'h0, 32'h104, 32'h0, 1'b1);
                do_d(4'h0, 32'h108, 32'h0, 1'b0);
            end
            begin
                do_if(32'h200, 1'b1);
                do_if(32'h204, 1'b1);
                do_if(32'h208, 1'b0);
            end
        join
        checks++;
        if (grant_log.size() != 6) begin
            errors++;
            $display("FAIL contention_count got=%0d exp=6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) check2("contention_order", grant_log[i], exp_pat[i]);
        end
        repeat (3) @(negedge ACLK);

        do_d(4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_if(32'h10, 1'b0);
        repeat (3) @(negedge ACLK);
        checks++;
        if (last_if_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_then_fetch got=%h exp=deadbeef", last_if_rdata);
        end

        do_d(4'b0010, 32'h10, 32'h0000_AB00, 1'b0);
        do_d(4'h0, 32'h12, 32'h0, 1'b0);
        repeat (3) @(negedge ACLK);
        checks++;
        if (last_d_rdata !== 32'hDEAD_ABEF) begin
            errors++;
            $display("FAIL byte_strobe got=%h exp=deadabef", last_d_rdata);
        end

        do_if(32'h1000, 1'b0);
        repeat (3) @(negedge ACLK);
        checks++;
        if (last_if_err !== 1'b1 || last_if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL range_fetch got err=%b data=%h exp err=1 data=0", last_if_err, last_if_rdata);
        end

        do_d(4'hF, 32'h2000_0010, 32'h0BAD_0BAD, 1'b0);
        repeat (3) @(negedge ACLK);
        checks++;
        if (last_d_err !== 1'b1) begin
            errors++;
            $display("FAIL range_write got err=%b exp err=1", last_d_err);
        end
        do_if(32'h10, 1'b0);
        repeat (3) @(negedge ACLK);
        checks++;
        if (last_if_rdata !== 32'hDEAD_ABEF) begin
            errors++;
            $display("FAIL range_write_no_effect got=%h exp=deadabef", last_if_rdata);
        end
        @(posedge ACLK); #1;

        // Randomized traffic on both ports, including back-to-back requests.
        fork
            begin
                bit keep = 1'b0;
                for (int i = 0; i < 150; i++) begin
                    if (!keep) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
                    keep = ($urandom_range(0, 1) == 1) && (i < 149);
                    do_if(rnd_addr(), keep);
                end
            end
            begin
                bit keep = 1'b0;
                logic [3:0] we;
                for (int i = 0; i < 150; i++) begin
                    if (!keep) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
                    keep = ($urandom_range(0, 1) == 1) && (i < 149);
                    we = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
                    do_d(we, rnd_addr(), $urandom, keep);
                end
            end
        join
        repeat (5) @(negedge ACLK);
        checks++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending if=%0d d=%0d exp 0", if_q.size(), d_q.size());
        end

        // RD_LAT=2 instance: a normal read response, then reset while a read is in flight.
        @(posedge ACLK); #1;
        r2 = 1'b0;
        d2_req = 1'b1;
        d2_addr = 32'h20;
        @(negedge ACLK);
        check2("lat2_gnt", d2_gnt, 1'b1);
        @(posedge ACLK); #1;
        d2_req = 1'b0;
        @(negedge ACLK);
        check2("lat2_n1_rvalid", d2_rvalid, 1'b0);
        @(negedge ACLK);
        check2("lat2_n2_rvalid", d2_rvalid, 1'b1);
        checks++;
        if (d2_rdata !== 32'h1234_5678 || d2_err !== 1'b0) begin
            errors++;
            $display("FAIL lat2_data got=%h err=%b exp=12345678 err=0", d2_rdata, d2_err);
        end
        @(negedge ACLK);
        check2("lat2_n3_rvalid", d2_rvalid, 1'b0);

        @(posedge ACLK); #1;
        d2_req = 1'b1;
        d2_addr = 32'h24;
        @(negedge ACLK);
        check2("midrst_gnt", d2_gnt, 1'b1);
        @(posedge ACLK); #1;
        d2_req = 1'b0;
        r2 = 1'b1;
        @(negedge ACLK);
        check2("midrst_n1_rvalid", d2_rvalid, 1'b0);
        @(posedge ACLK); #1;
        r2 = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge ACLK);
            check2("midrst_rvalid", d2_rvalid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
